airlock_sequencer: RTL and testbench
====================================

AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 SHALL have parameter DOOR_CYCLES, default 4: cycles a door is held open per phase; legal range 1..255.
REQ-002 SHALL have parameter FILL_CYCLES, default 8: cycles to raise the chamber to inner level; legal range 1..255.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 6: cycles to lower the chamber to outer level; legal range 1..255.
REQ-004 SHALL have port Clock  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port OutReq  input  1  craft outside requests entry, sampled every edge.
REQ-007 SHALL have port InReq  input  1  craft inside requests exit, sampled every edge.
REQ-008 SHALL have port Hold  input  1  obstruction; freezes the current timed phase while high.
REQ-009 SHALL have port OuterOpen  output  1  outer-door open command, one per door port controller.
REQ-010 SHALL have port InnerOpen  output  1  inner-door open command.
REQ-011 SHALL have port Fill  output  1  pump command raising chamber level.
REQ-012 SHALL have port Drain  output  1  vent command lowering chamber level.
REQ-013 SHALL have port Level  output  1  chamber level: 0 = outer (LOW), 1 = inner (HIGH).
REQ-014 SHALL have port Busy  output  1  high in every non-IDLE state.
REQ-015 SHALL have ports GrantOut, GrantIn  output  1 each  one-cycle pulse when a request is accepted.

Function
REQ-016 SHALL latch OutReq/InReq into PendOut/PendIn on the edge they are sampled high; repeated pulses before service SHALL collapse into one pending request.
REQ-017 SHALL clear a pending bit on the edge the FSM leaves IDLE to serve that side; a same-side request sampled on that edge SHALL remain pending.
REQ-018 SHALL implement states IDLE, DRAIN, OPEN_OUTER, FILL, OPEN_INNER, with all outputs Moore-decoded from registered state.
REQ-019 SHALL, serving outer: DRAIN (only if Level=1) -> OPEN_OUTER -> FILL -> OPEN_INNER -> IDLE.
REQ-020 SHALL, serving inner: FILL (only if Level=0) -> OPEN_INNER -> DRAIN -> OPEN_OUTER -> IDLE.
REQ-021 SHALL leave IDLE on the edge after a pending bit is set; outputs of the first phase visible after that edge.
REQ-022 SHALL, when both pending in IDLE, serve the side not served last (LastServed flag); single pending side served regardless of flag.
REQ-023 SHALL assert GrantOut/GrantIn for exactly the first cycle of the first phase of a service and update LastServed on the same edge.
REQ-024 SHALL load an 8-bit down-counter with N-1 on phase entry and exit the phase on the edge where counter=0 and Hold=0; each phase lasts exactly N cycles plus cycles with Hold high.
REQ-025 SHALL, while Hold=1, keep counter and state frozen with phase outputs unchanged.
REQ-026 SHALL set Level=1 on the edge FILL exits and Level=0 on the edge DRAIN exits.
REQ-027 SHALL never assert OuterOpen and InnerOpen together, nor either door with Fill or Drain, nor Fill with Drain.
REQ-028 SHALL have no idle cycle between consecutive phases of one service.
REQ-029 SHALL ignore Hold in IDLE.

Reset
REQ-030 SHALL, on any edge with Reset=0 (including mid-phase), enter IDLE, set Level=0, clear PendOut/PendIn and counter, set LastServed=inner, and drive all other outputs 0.
REQ-031 SHALL discard requests sampled on an edge where Reset=0.

Verification
REQ-032 SHALL verify: reset, OutReq pulse, Level=0 -> GrantOut 1 cycle, OuterOpen 4, Fill 8, InnerOpen 4, Level=1, Busy 16 cycles.
REQ-033 SHALL verify: reset, InReq pulse -> Fill 8, InnerOpen 4, Drain 6, OuterOpen 4, Level ends 0, Busy 22 cycles.
REQ-034 SHALL verify: OutReq and InReq same edge after reset -> outer served first (16 cycles), inner starts next edge after IDLE (FILL skipped, Level=1).
REQ-035 SHALL verify: Hold high 3 cycles mid-FILL -> Fill lasts 11 cycles, counter frozen, no door opens.
REQ-036 SHALL verify: Reset low mid-FILL with InReq pending -> next edge all outputs 0, Level=0, pending cleared, no service follows.
REQ-037 SHALL verify: three OutReq pulses during a busy inner service -> exactly one outer service afterward; exclusivity assertions (REQ-027) hold throughout.

Source files
------------

// File: rtl/airlock_sequencer_if.sv
// Request/command bundle between the airlock sequencer and its environment.
// The master drives requests and the obstruction flag; the slave drives door, pump and status lines.
interface airlock_sequencer_if;
    logic OutReq;
    logic InReq;
    logic Hold;
    logic OuterOpen;
    logic InnerOpen;
    logic Fill;
    logic Drain;
    logic Level;
    logic Busy;
    logic GrantOut;
    logic GrantIn;

    modport master (
        output OutReq,
        output InReq,
        output Hold,
        input  OuterOpen,
        input  InnerOpen,
        input  Fill,
        input  Drain,
        input  Level,
        input  Busy,
        input  GrantOut,
        input  GrantIn
    );

    modport slave (
        input  OutReq,
        input  InReq,
        input  Hold,
        output OuterOpen,
        output InnerOpen,
        output Fill,
        output Drain,
        output Level,
        output Busy,
        output GrantOut,
        output GrantIn
    );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock sequencer: serves entry/exit requests by cycling doors and chamber level
// through timed phases, with obstruction hold and fair arbitration between sides.
module airlock_sequencer #(
    parameter int unsigned DOOR_CYCLES  = 4,
    parameter int unsigned FILL_CYCLES  = 8,
    parameter int unsigned DRAIN_CYCLES = 6
) (
    input  logic                Clock,
    input  logic                Reset,
    airlock_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DRAIN      = 3'd1,
        S_OPEN_OUTER = 3'd2,
        S_FILL       = 3'd3,
        S_OPEN_INNER = 3'd4
    } state_t;

    localparam logic [7:0] DOOR_LOAD  = 8'(DOOR_CYCLES - 32'd1);
    localparam logic [7:0] FILL_LOAD  = 8'(FILL_CYCLES - 32'd1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 32'd1);

    // Counter preload for a phase: the phase lasts load+1 unheld cycles.
    function automatic logic [7:0] phase_load(input state_t s);
        case (s)
            S_DRAIN:      return DRAIN_LOAD;
            S_OPEN_OUTER: return DOOR_LOAD;
            S_FILL:       return FILL_LOAD;
            S_OPEN_INNER: return DOOR_LOAD;
            default:      return 8'd0;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_level;
    logic        r_pend_out;
    logic        r_pend_in;
    logic        r_last_in;
    logic        r_serve_in;
    logic        r_grant_out;
    logic        r_grant_in;
    logic        w_serve_out;
    logic        w_serve_in;
    logic        w_phase_done;
    logic        w_outer_open;
    logic        w_inner_open;
    logic        w_fill;
    logic        w_drain;
    logic        w_busy;

    assign w_phase_done = (r_state != S_IDLE) && (r_cnt == 8'd0) && !bus.Hold;

    // IDLE arbitration: alternate when both sides wait, otherwise take whoever is pending.
    always_comb begin
        w_serve_out = 1'b0;
        w_serve_in  = 1'b0;
        if (r_state == S_IDLE) begin
            if (r_pend_out && r_pend_in) begin
                w_serve_out = r_last_in;
                w_serve_in  = ~r_last_in;
            end else begin
                w_serve_out = r_pend_out;
                w_serve_in  = r_pend_in;
            end
        end else begin
            w_serve_out = 1'b0;
            w_serve_in  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: door phases close out a service or hand over to the level change.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_serve_out) begin
                    w_state_next = r_level ? S_DRAIN : S_OPEN_OUTER;
                end else if (w_serve_in) begin
                    w_state_next = r_level ? S_OPEN_INNER : S_FILL;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_phase_done) w_state_next = S_OPEN_OUTER;
                else              w_state_next = S_DRAIN;
            end
            S_OPEN_OUTER: begin
                if (w_phase_done) w_state_next = r_serve_in ? S_IDLE : S_FILL;
                else              w_state_next = S_OPEN_OUTER;
            end
            S_FILL: begin
                if (w_phase_done) w_state_next = S_OPEN_INNER;
                else              w_state_next = S_FILL;
            end
            S_OPEN_INNER: begin
                if (w_phase_done) w_state_next = r_serve_in ? S_DRAIN : S_IDLE;
                else              w_state_next = S_OPEN_INNER;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Phase timer, chamber level, pending requests, arbitration history and grant pulses.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_cnt       <= 8'd0;
            r_level     <= 1'b0;
            r_pend_out  <= 1'b0;
            r_pend_in   <= 1'b0;
            r_last_in   <= 1'b1;
            r_serve_in  <= 1'b0;
            r_grant_out <= 1'b0;
            r_grant_in  <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= phase_load(w_state_next);
            end else if (!bus.Hold && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            if ((r_state == S_FILL) && w_phase_done) begin
                r_level <= 1'b1;
            end else if ((r_state == S_DRAIN) && w_phase_done) begin
                r_level <= 1'b0;
            end else begin
                r_level <= r_level;
            end

            // A request arriving on the accepting edge survives the clear.
            r_pend_out <= (r_pend_out & ~w_serve_out) | bus.OutReq;
            r_pend_in  <= (r_pend_in  & ~w_serve_in)  | bus.InReq;

            r_grant_out <= w_serve_out;
            r_grant_in  <= w_serve_in;

            if (w_serve_out || w_serve_in) begin
                r_last_in  <= w_serve_in;
                r_serve_in <= w_serve_in;
            end else begin
                r_last_in  <= r_last_in;
                r_serve_in <= r_serve_in;
            end
        end
    end

    // Moore output decode: exactly one actuator per non-IDLE state.
    always_comb begin
        w_outer_open = 1'b0;
        w_inner_open = 1'b0;
        w_fill       = 1'b0;
        w_drain      = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE:       w_busy       = 1'b0;
            S_DRAIN:      w_drain      = 1'b1;
            S_OPEN_OUTER: w_outer_open = 1'b1;
            S_FILL:       w_fill       = 1'b1;
            S_OPEN_INNER: w_inner_open = 1'b1;
            default:      w_busy       = 1'b0;
        endcase
    end

    assign bus.OuterOpen = w_outer_open;
    assign bus.InnerOpen = w_inner_open;
    assign bus.Fill      = w_fill;
    assign bus.Drain     = w_drain;
    assign bus.Busy      = w_busy;
    assign bus.Level     = r_level;
    assign bus.GrantOut  = r_grant_out;
    assign bus.GrantIn   = r_grant_in;
endmodule

// File: tb/tb_airlock_sequencer.sv
// Scoreboard bench for airlock_sequencer: a phase-plan reference model queues expected
// phases (pattern, start cycle, length, grant, level); a monitor rebuilds phases from the DUT.
module tb_airlock_sequencer;
    localparam int DOOR   = 4;
    localparam int FILLN  = 8;
    localparam int DRAINN = 6;

    localparam logic [3:0] P_OUTER = 4'b1000;
    localparam logic [3:0] P_INNER = 4'b0100;
    localparam logic [3:0] P_FILL  = 4'b0010;
    localparam logic [3:0] P_DRAIN = 4'b0001;

    typedef struct {
        logic [3:0] pat;
        int         start;
        int         len;
        logic [1:0] grant;
        logic       level;
    } seg_t;

    logic Clock;
    logic Reset;
    airlock_sequencer_if bus();

    airlock_sequencer #(
        .DOOR_CYCLES (DOOR),
        .FILL_CYCLES (FILLN),
        .DRAIN_CYCLES(DRAINN)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    seg_t exp_q[$];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // ---------------- reference model: services expand into phase plans ----------------
    int         m_cyc = 0;
    logic       m_pend_out, m_pend_in, m_last_in, m_level, m_active;
    logic [3:0] m_pat;
    int         m_start, m_len, m_rem;
    logic [1:0] m_grant;
    logic [3:0] m_plan[$];

    function automatic int dur(input logic [3:0] p);
        case (p)
            P_FILL:  return FILLN;
            P_DRAIN: return DRAINN;
            default: return DOOR;
        endcase
    endfunction

    task automatic start_phase(input logic [3:0] p, input logic [1:0] g);
        m_active = 1'b1; m_pat = p; m_start = m_cyc; m_len = 1; m_rem = dur(p); m_grant = g;
    endtask

    task automatic close_phase();
        seg_t s;
        s.pat = m_pat; s.start = m_start; s.len = m_len; s.grant = m_grant; s.level = m_level;
        exp_q.push_back(s);
    endtask

    initial begin
        logic take_out;
        m_pend_out = 1'b0; m_pend_in = 1'b0; m_last_in = 1'b1; m_level = 1'b0; m_active = 1'b0;
        forever begin
            @(posedge Clock);
            m_cyc++;
            if (!Reset) begin
                if (m_active) close_phase();
                m_active = 1'b0; m_plan.delete();
                m_pend_out = 1'b0; m_pend_in = 1'b0; m_level = 1'b0; m_last_in = 1'b1;
            end else begin
                if (m_active) begin
                    if (bus.Hold) begin
                        m_len++;
                    end else if (m_rem == 1) begin
                        close_phase();
                        if (m_pat == P_FILL) m_level = 1'b1;
                        if (m_pat == P_DRAIN) m_level = 1'b0;
                        if (m_plan.size() > 0) start_phase(m_plan.pop_front(), 2'b00);
                        else m_active = 1'b0;
                    end else begin
                        m_rem--; m_len++;
                    end
                end else if (m_pend_out || m_pend_in) begin
                    take_out = m_pend_out && (!m_pend_in || m_last_in);
                    if (take_out) begin
                        if (m_level) m_plan.push_back(P_DRAIN);
                        m_plan.push_back(P_OUTER); m_plan.push_back(P_FILL); m_plan.push_back(P_INNER);
                        m_pend_out = 1'b0;
                    end else begin
                        if (!m_level) m_plan.push_back(P_FILL);
                        m_plan.push_back(P_INNER); m_plan.push_back(P_DRAIN); m_plan.push_back(P_OUTER);
                        m_pend_in = 1'b0;
                    end
                    m_last_in = !take_out;
                    start_phase(m_plan.pop_front(), take_out ? 2'b10 : 2'b01);
                end
                m_pend_out = m_pend_out | bus.OutReq;
                m_pend_in  = m_pend_in  | bus.InReq;
            end
        end
    end

    // ---------------- monitor: rebuild phases from DUT outputs ----------------
    int         mon_cyc = 0;
    logic [3:0] cur_pat = 4'b0000;
    int         cur_start, cur_len;
    logic [1:0] cur_grant;
    logic       cur_level, cur_bad;
    int         busy_run = 0, last_busy_run = 0, busy_total = 0, last_fill_len = 0;
    int         gout_cnt = 0, gin_cnt = 0;

    task automatic close_seg();
        seg_t e;
        tests++;
        if (cur_pat == P_FILL) last_fill_len = cur_len;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL phase_seq: unexpected phase pat=%b start=%0d len=%0d", cur_pat, cur_start, cur_len);
        end else begin
            e = exp_q.pop_front();
            if (e.pat != cur_pat || e.start != cur_start || e.len != cur_len ||
                e.grant != cur_grant || e.level != cur_level || cur_bad) begin
                fails++;
                $display("FAIL phase_seq: got pat=%b start=%0d len=%0d grant=%b level=%b glitch=%b, expected pat=%b start=%0d len=%0d grant=%b level=%b",
                         cur_pat, cur_start, cur_len, cur_grant, cur_level, cur_bad,
                         e.pat, e.start, e.len, e.grant, e.level);
            end
        end
    endtask

    initial begin
        logic [3:0] pat;
        logic [1:0] gr;
        logic       ok;
        forever begin
            @(negedge Clock);
            mon_cyc++;
            pat = {bus.OuterOpen, bus.InnerOpen, bus.Fill, bus.Drain};
            gr  = {bus.GrantOut, bus.GrantIn};
            ok  = ($countones(pat) <= 1) && (bus.Busy == (pat != 4'b0000)) &&
                  (gr != 2'b11) && ((gr == 2'b00) || (pat != 4'b0000));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL exclusivity: cycle %0d outputs pat=%b busy=%b grant=%b, required at most one actuator and consistent busy/grant",
                         mon_cyc, pat, bus.Busy, gr);
            end
            gout_cnt += int'(bus.GrantOut);
            gin_cnt  += int'(bus.GrantIn);
            if (bus.Busy) begin
                busy_run++; busy_total++;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run; busy_run = 0;
            end
            if (pat != cur_pat) begin
                if (cur_pat != 4'b0000) close_seg();
                if (pat != 4'b0000) begin
                    cur_start = mon_cyc; cur_len = 1; cur_grant = gr; cur_level = bus.Level; cur_bad = 1'b0;
                end
                cur_pat = pat;
            end else if (pat != 4'b0000) begin
                cur_len++;
                if (gr != 2'b00 || bus.Level != cur_level) cur_bad = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0; tick(n); Reset = 1'b1;
    endtask

    task automatic pulse_out();
        bus.OutReq = 1'b1; tick(1); bus.OutReq = 1'b0;
    endtask

    task automatic pulse_in();
        bus.InReq = 1'b1; tick(1); bus.InReq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_active || m_pend_out || m_pend_in || bus.Busy) && n < 400) begin
            tick(1);
            n++;
        end
        if (n >= 400) begin
            tests++; fails++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({bus.OuterOpen, bus.InnerOpen, bus.Fill, bus.Drain, bus.Busy,
                          bus.GrantOut, bus.GrantIn, bus.Level}), 0);
    endtask

    initial begin
        int snap_o, snap_i, snap_b;
        Reset = 1'b0; bus.OutReq = 1'b0; bus.InReq = 1'b0; bus.Hold = 1'b0;
        tick(3);
        Reset = 1'b1;
        check_all_zero("reset_state");

        // Outer entry from low level.
        do_reset(1);
        snap_o = gout_cnt;
        pulse_out();
        wait_idle("outer");
        check("outer_busy_cycles", last_busy_run, 2 * DOOR + FILLN);
        check("outer_level_end", int'(bus.Level), 1);
        check("outer_grant_count", gout_cnt - snap_o, 1);

        // Inner exit from low level.
        do_reset(1);
        pulse_in();
        wait_idle("inner");
        check("inner_busy_cycles", last_busy_run, 2 * DOOR + FILLN + DRAINN);
        check("inner_level_end", int'(bus.Level), 0);

        // Simultaneous requests: outer first, then inner with FILL skipped.
        do_reset(1);
        snap_o = gout_cnt; snap_i = gin_cnt;
        bus.OutReq = 1'b1; bus.InReq = 1'b1; tick(1); bus.OutReq = 1'b0; bus.InReq = 1'b0;
        wait_idle("both");
        check("both_grant_out", gout_cnt - snap_o, 1);
        check("both_grant_in", gin_cnt - snap_i, 1);
        check("both_second_busy", last_busy_run, 2 * DOOR + DRAINN);
        check("both_level_end", int'(bus.Level), 0);

        // Hold for 3 cycles in the middle of FILL.
        do_reset(1);
        pulse_in();
        tick(3);
        bus.Hold = 1'b1; tick(3); bus.Hold = 1'b0;
        wait_idle("hold");
        check("hold_fill_len", last_fill_len, FILLN + 3);

        // Reset mid-FILL with an inner request pending.
        do_reset(1);
        pulse_in();
        tick(3);
        pulse_in();
        Reset = 1'b0; tick(1); Reset = 1'b1;
        check_all_zero("midreset_outputs");
        snap_b = busy_total;
        tick(30);
        check("midreset_no_service", busy_total - snap_b, 0);

        // Three outer pulses during an inner service collapse into one.
        do_reset(1);
        snap_o = gout_cnt;
        pulse_in();
        tick(5); pulse_out();
        tick(4); pulse_out();
        tick(6); pulse_out();
        wait_idle("collapse");
        check("collapse_outer_grants", gout_cnt - snap_o, 1);

        // Randomized traffic with holds and occasional resets.
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            bus.OutReq = ($urandom_range(0, 9) == 0);
            bus.InReq  = ($urandom_range(0, 9) == 0);
            bus.Hold   = ($urandom_range(0, 4) == 0);
            Reset      = !($urandom_range(0, 199) == 0);
            tick(1);
        end
        bus.OutReq = 1'b0; bus.InReq = 1'b0; bus.Hold = 1'b0; Reset = 1'b1;
        tick(1);
        wait_idle("random");
        tick(2);
        check("queue_drained", exp_q.size(), 0);
        check("no_open_phase", int'(cur_pat), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
